// File: rtl/csa_acc_46bit.sv
// Streaming reduction stage: accumulates i_len operands through a carry-select adder and reports {carry count, sum}.
// Latency: one operand per cycle; the result is valid the cycle after the last accepted operand.
// Backpressure: o_ready is high only while accumulating; the result is held in DONE until i_ready accepts it.

module csa_46bit #(
   parameter int WIDTH = 46,
   parameter int BLK   = 8
) (
   input  logic [WIDTH-1:0] i_add_term1,
   input  logic [WIDTH-1:0] i_add_term2,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NBLK = (WIDTH + BLK - 1) / BLK;

   logic [NBLK:0] blk_carry;

   assign blk_carry[0] = 1'b0;
   assign cout         = blk_carry[NBLK];

   // Each block precomputes both carry-in cases; the incoming block carry picks one.
   for (genvar b = 0; b < NBLK; b++) begin : g_blk
      localparam int LO = b * BLK;
      localparam int HI = ((LO + BLK) > WIDTH) ? (WIDTH - 1) : (LO + BLK - 1);
      localparam int BW = HI - LO + 1;

      logic [BW:0] s0;
      logic [BW:0] s1;

      assign s0 = {1'b0, i_add_term1[HI:LO]} + {1'b0, i_add_term2[HI:LO]};
      assign s1 = s0 + {{BW{1'b0}}, 1'b1};

      assign sum[HI:LO]     = blk_carry[b] ? s1[BW-1:0] : s0[BW-1:0];
      assign blk_carry[b+1] = blk_carry[b] ? s1[BW]     : s0[BW];
   end
endmodule

module csa_acc_46bit #(
   parameter int WIDTH = 46,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_len,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic [CNT_W-1:0] o_carry_cnt,
   output logic             o_busy
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] carry_cnt;
   logic [CNT_W-1:0] remaining;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic             beat;

   csa_46bit #(.WIDTH(WIDTH)) u_csa (
      .i_add_term1 (acc),
      .i_add_term2 (i_data),
      .sum         (add_sum),
      .cout        (add_cout)
   );

   assign o_ready     = (state == ACC);
   assign o_valid     = (state == DONE);
   assign o_busy      = (state != IDLE);
   assign o_sum       = acc;
   assign o_carry_cnt = carry_cnt;
   assign beat        = i_valid & o_ready;

   // Job control and accumulation; the carry count forms the upper word of the exact total.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         carry_cnt <= '0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  acc       <= '0;
                  carry_cnt <= '0;
                  remaining <= i_len;
                  state     <= (i_len != '0) ? ACC : DONE;
               end
            end
            ACC: begin
               if (beat) begin
                  acc       <= add_sum;
                  carry_cnt <= carry_cnt + {{(CNT_W-1){1'b0}}, add_cout};
                  remaining <= remaining - {{(CNT_W-1){1'b0}}, 1'b1};
                  if (remaining == {{(CNT_W-1){1'b0}}, 1'b1})
                     state <= DONE;
               end
            end
            DONE: begin
               if (i_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csa_acc_46bit.sv
// Randomized bench for csa_acc_46bit with a queue scoreboard and a separate result monitor.
// Latency: checks o_ready/o_valid timing around job start, last beat and transfer.
// Backpressure: holds i_ready low in DONE and checks the result is held.

module tb_csa_acc_46bit;
   localparam int WIDTH = 46;
   localparam int CNT_W = 8;

   logic             i_clk = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_start = 1'b0;
   logic [CNT_W-1:0] i_len = '0;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [WIDTH-1:0] i_data = '0;
   logic             o_valid;
   logic             i_ready = 1'b0;
   logic [WIDTH-1:0] o_sum;
   logic [CNT_W-1:0] o_carry_cnt;
   logic             o_busy;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   csa_acc_46bit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_len       (i_len),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (i_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_sum       (o_sum),
      .o_carry_cnt (o_carry_cnt),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: whenever a result is presented, compare it with the oldest expected total.
   always @(negedge i_clk) begin
      if (i_rst_n && o_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL result_unexpected: got 0x%0h with empty scoreboard", {o_carry_cnt, o_sum});
         end else begin
            check("result", {10'd0, o_carry_cnt, o_sum}, exp_q[0]);
            if (i_ready) void'(exp_q.pop_front());
         end
      end
   end

   function automatic logic [WIDTH-1:0] rand_op();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[WIDTH-1:0];
   endfunction

   // mode 0: random operands, 1: all-ones operands, 2: operands 1,2,3,...
   task automatic run_job(input int len, input int mode, input bit gaps, input int hold, input bit poke);
      logic [WIDTH-1:0] ops[$];
      logic [63:0] total;
      total = 64'd0;
      for (int k = 0; k < len; k++) begin
         logic [WIDTH-1:0] v;
         if (mode == 1) v = {WIDTH{1'b1}};
         else if (mode == 2) v = WIDTH'(k + 1);
         else v = rand_op();
         ops.push_back(v);
         total = total + {18'd0, v};
      end
      exp_q.push_back(total);

      i_start = 1'b1;
      i_len   = CNT_W'(len);
      @(posedge i_clk); #1;
      i_start = 1'b0;
      check("busy_after_start", {63'd0, o_busy}, 64'd1);
      if (len == 0) check("valid_zero_len", {63'd0, o_valid}, 64'd1);
      else          check("ready_after_start", {63'd0, o_ready}, 64'd1);

      for (int k = 0; k < len; k++) begin
         if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
               i_valid = 1'b0;
               i_data  = rand_op();
               @(posedge i_clk); #1;
            end
         end
         if (k == 0 || gaps) check("ready_in_acc", {63'd0, o_ready}, 64'd1);
         i_valid = 1'b1;
         i_data  = ops[k];
         if (poke && k == 1) begin
            i_start = 1'b1;
            i_len   = CNT_W'($urandom_range(1, 255));
         end
         @(posedge i_clk); #1;
         i_start = 1'b0;
      end

      // Keep offering junk so any extra accepted beat would corrupt the held total.
      i_valid = 1'b1;
      i_data  = rand_op();
      check("valid_after_last", {63'd0, o_valid}, 64'd1);
      check("ready_low_done", {63'd0, o_ready}, 64'd0);
      for (int h = 0; h < hold; h++) begin
         i_ready = 1'b0;
         @(posedge i_clk); #1;
         check("valid_held", {63'd0, o_valid}, 64'd1);
      end
      i_ready = 1'b1;
      if (poke) begin
         i_start = 1'b1;
         i_len   = 8'd3;
      end
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      i_start = 1'b0;
      i_valid = 1'b0;
      check("idle_after_xfer", {62'd0, o_busy, o_valid}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("reset_outputs", {o_carry_cnt, o_sum, o_ready, o_valid, o_busy}, 64'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      run_job(3, 2, 1'b0, 0, 1'b0);   // 1+2+3
      run_job(4, 1, 1'b0, 1, 1'b0);   // four times 2^46-1: three carries
      run_job(2, 0, 1'b1, 5, 1'b0);   // bubbles and backpressure
      run_job(0, 0, 1'b0, 1, 1'b0);   // zero length
      run_job(6, 0, 1'b0, 2, 1'b1);   // i_start ignored in ACC and DONE

      // Abort a job asynchronously, away from any clock edge.
      i_start = 1'b1;
      i_len   = 8'd5;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         i_valid = 1'b1;
         i_data  = WIDTH'(k + 100);
         @(posedge i_clk); #1;
      end
      i_valid = 1'b0;
      #1;
      i_rst_n = 1'b0;
      #1;
      check("async_reset", {o_carry_cnt, o_sum, o_ready, o_valid, o_busy}, 64'd0);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      check("idle_after_reset", {62'd0, o_busy, o_valid}, 64'd0);

      run_job(3, 2, 1'b0, 0, 1'b0);
      run_job(255, 1, 1'b0, 0, 1'b0); // carry count reaches 254 without overflow
      for (int j = 0; j < 8; j++)
         run_job($urandom_range(1, 255), 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

      repeat (2) @(posedge i_clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/csa_acc_46bit.md
# csa_acc_46bit

Sequential accumulator that sits directly downstream of the 46-bit carry-select adder `csa_46bit`. It instantiates one `csa_46bit` and feeds it the running accumulator and each incoming operand. It registers the adder's `sum` and counts its `cout` pulses. After a programmed number of operands it presents the exact multi-word total through a valid/ready output handshake. The block turns the combinational adder into a streaming reduction stage for the batch-adder test flow.

## Interface
Parameters:
- `WIDTH`, 46: operand and accumulator width; must match the `csa_46bit` width.
- `CNT_W`, 8: width of the length and carry-count fields.

Ports:
- `i_clk` in 1: clock; all state is updated on the rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_start` in 1: one-cycle request to begin a new accumulation; sampled only in IDLE.
- `i_len` in CNT_W: number of operands to accumulate; sampled together with `i_start`.
- `i_valid` in 1: the input operand is valid.
- `o_ready` out 1: the block accepts an operand this cycle.
- `i_data` in WIDTH: input operand.
- `o_valid` out 1: the result is valid.
- `i_ready` in 1: the downstream stage accepts the result.
- `o_sum` out WIDTH: low WIDTH bits of the total.
- `o_carry_cnt` out CNT_W: count of adder carry-outs, i.e. the upper bits of the total.
- `o_busy` out 1: high whenever the state is not IDLE.

## Operation
- The `csa_46bit` instance has `i_add_term1` = accumulator register and `i_add_term2` = `i_data`. It is combinational, with a single-cycle path and no internal pipelining.
- **FSM states: IDLE, ACC, DONE.**
- **IDLE**
  - `o_ready`=0, `o_valid`=0.
  - `i_start`=1 with `i_len`≠0: accumulator←0, carry count←0, remaining←`i_len`, next state ACC.
  - `i_start`=1 with `i_len`=0: accumulator←0, carry count←0, next state DONE.
- **ACC**
  - `o_ready`=1.
  - On a beat (`i_valid`&`o_ready`): accumulator←adder `sum`, carry count←carry count+`cout`, remaining←remaining−1.
  - A beat while remaining=1 moves the FSM to DONE.
  - With no beat, all state holds.
- **DONE**
  - `o_valid`=1; `o_sum` and `o_carry_cnt` are held stable.
  - When `i_ready`=1 the result transfers and the next state is IDLE.
  - `o_valid` must not drop before the transfer.
- `i_start` is ignored in ACC and DONE; a new job can begin only from IDLE.
- **Width rule:** each addition produces at most one carry.
  - With `i_len` ≤ 2^CNT_W−1, `o_carry_cnt` cannot overflow.
  - {`o_carry_cnt`,`o_sum`} equals the exact sum of all accepted operands.
  - No saturation logic is required.
- `o_sum` and `o_carry_cnt` are driven directly from their registers. They change only on accepted beats and on job start.

## Timing
- **Reset values:** state IDLE, `o_ready`=0, `o_valid`=0, `o_busy`=0, `o_sum`=0, `o_carry_cnt`=0, remaining=0.
- **Reset mid-operation** (`i_rst_n` low in ACC or DONE): the block returns to IDLE immediately, without waiting for a clock edge. All outputs take their reset values, a pending result is discarded, and the next job needs a new `i_start`.
- **Job start:** `i_start` in cycle t gives `o_busy`=1 in t+1 and `o_ready`=1 in t+1, or `o_valid`=1 in t+1 if `i_len`=0.
- **Throughput:** one operand per cycle while `i_valid` stays high.
- **Latency:** last beat accepted in cycle t, then `o_valid`=1 in t+1. `o_ready` is 0 in t+1, so no extra beat is accepted.
- **Result transfer:** `i_ready` high during DONE in cycle t gives IDLE in t+1. A new `i_start` may then be sampled in t+1.
- **Simultaneous events:** `i_start` in the same cycle as the result transfer (DONE) is ignored. `i_valid` while in IDLE or DONE is ignored.

## Test plan
- **Reset:** assert `i_rst_n`=0 asynchronously mid-ACC → outputs 0 and state IDLE without a clock edge. The next job runs correctly.
- **Basic:** `i_len`=3, operands 1, 2, 3 on consecutive cycles → `o_valid` one cycle after the 3rd beat. `o_sum`=6, `o_carry_cnt`=0.
- **Carry counting:** `i_len`=4, each operand 0x3FFF_FFFF_FFFF (2^46−1) → `o_sum`=0x3FFF_FFFF_FFFC, `o_carry_cnt`=3.
- **Backpressure and gaps:** `i_len`=2 with `i_valid` bubbles between beats, then `i_ready` held low 5 cycles in DONE → result stable and `o_valid` held all 5 cycles. Transfer on `i_ready`=1, then IDLE.
- **Zero length:** `i_start` with `i_len`=0 → `o_valid` next cycle with `o_sum`=0 and `o_carry_cnt`=0. `i_data` is never accepted.
- **Ignored inputs:** `i_start` pulsed during ACC and during the DONE handshake cycle → no restart, and totals are unchanged. Random `i_len`≤255 streams match a 54-bit scoreboard sum.
